// File: rtl/cmp_pkg.sv
// Shared definitions for the min/max sequencer: sample width and FSM state encoding.
package cmp_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        WAIT,
        CMP_MAX,
        CMP_MIN,
        DONE
    } state_t;

endpackage

// File: rtl/bitcomparex16.sv
// 16-bit unsigned magnitude comparator; exactly one of agreat/bgreat/equal is high.
module bitcomparex16
    import cmp_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              agreat,
    output logic              bgreat,
    output logic              equal
);

    assign agreat = (a > b);
    assign bgreat = (b > a);
    assign equal  = (a == b);

endmodule

// File: rtl/cmp_minmax_seq.sv
// Burst max/min finder time-sharing one magnitude comparator across the max and min checks.
// Define CMP_MINMAX_DUALCMP_EN for two comparators and a merged compare state (2 cycles/sample).
module cmp_minmax_seq
    import cmp_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    output logic [CNT_W-1:0]  max_idx,
    output logic [CNT_W-1:0]  min_idx
);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  len_reg;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_inc;
    logic [DATA_W-1:0] s_reg;
    logic              accept;
    logic              upd_max;
    logic              upd_min;
    logic              last_cmp;
    logic              ready_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    assign accept    = in_valid & in_ready;
    assign count_inc = count + CNT_W'(1);

`ifdef CMP_MINMAX_DUALCMP_EN
    logic mx_agreat, mx_bgreat, mx_equal;
    logic mn_agreat, mn_bgreat, mn_equal;

    bitcomparex16 u_cmp_max (
        .a      (s_reg),
        .b      (max_val),
        .agreat (mx_agreat),
        .bgreat (mx_bgreat),
        .equal  (mx_equal)
    );

    bitcomparex16 u_cmp_min (
        .a      (s_reg),
        .b      (min_val),
        .agreat (mn_agreat),
        .bgreat (mn_bgreat),
        .equal  (mn_equal)
    );

    assign last_cmp = (state == CMP_MAX);
    assign upd_max  = last_cmp & mx_agreat & ~(mx_equal | mx_bgreat);
    assign upd_min  = last_cmp & mn_bgreat & ~(mn_equal | mn_agreat);
`else
    logic [DATA_W-1:0] cmp_b;
    logic              cmp_agreat, cmp_bgreat, cmp_equal;

    // One comparator: the running max is the reference in CMP_MAX, the running min in CMP_MIN.
    assign cmp_b = (state == CMP_MIN) ? min_val : max_val;

    bitcomparex16 u_cmp (
        .a      (s_reg),
        .b      (cmp_b),
        .agreat (cmp_agreat),
        .bgreat (cmp_bgreat),
        .equal  (cmp_equal)
    );

    assign last_cmp = (state == CMP_MIN);
    assign upd_max  = (state == CMP_MAX) & cmp_agreat & ~(cmp_equal | cmp_bgreat);
    assign upd_min  = (state == CMP_MIN) & cmp_bgreat & ~(cmp_equal | cmp_agreat);
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (len == '0) ? DONE : FIRST;
            FIRST:   if (accept) next_state = (len_reg == CNT_W'(1)) ? DONE : WAIT;
            WAIT:    if (accept) next_state = CMP_MAX;
`ifdef CMP_MINMAX_DUALCMP_EN
            CMP_MAX: next_state = (count_inc == len_reg) ? DONE : WAIT;
`else
            CMP_MAX: next_state = CMP_MIN;
`endif
            CMP_MIN: next_state = (count_inc == len_reg) ? DONE : WAIT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are decoded from the upcoming state so they can be registered with it.
    always_comb begin
        ready_nxt = (next_state == FIRST) || (next_state == WAIT);
        busy_nxt  = (next_state != IDLE);
        done_nxt  = (next_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= ready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_reg <= '0;
            count   <= '0;
            s_reg   <= '0;
            max_val <= '0;
            min_val <= '0;
            max_idx <= '0;
            min_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_reg <= len;
                        count   <= '0;
                        if (len == '0) begin
                            max_val <= '0;
                            min_val <= '0;
                            max_idx <= '0;
                            min_idx <= '0;
                        end
                    end
                end
                FIRST: begin
                    if (accept) begin
                        max_val <= in_data;
                        min_val <= in_data;
                        max_idx <= '0;
                        min_idx <= '0;
                        count   <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (accept) s_reg <= in_data;
                end
                default: ;
            endcase

            if (upd_max) begin
                max_val <= s_reg;
                max_idx <= count;
            end
            if (upd_min) begin
                min_val <= s_reg;
                min_idx <= count;
            end
            if (last_cmp) count <= count_inc;
        end
    end

endmodule

// File: tb/tb_cmp_minmax_seq.sv
// Directed self-checking bench for cmp_minmax_seq (default or CMP_MINMAX_DUALCMP_EN build).
module tb_cmp_minmax_seq;

    localparam int CNT_W = 5;
`ifdef CMP_MINMAX_DUALCMP_EN
    localparam int CYC_PER = 2;
`else
    localparam int CYC_PER = 3;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             busy;
    logic             done;
    logic [15:0]      max_val;
    logic [15:0]      min_val;
    logic [CNT_W-1:0] max_idx;
    logic [CNT_W-1:0] min_idx;

    int          testsRun  = 0;
    int          failCount = 0;
    logic [15:0] sampleMem [0:31];
    int          burstCycles;
    int          burstAccepts;
    int          burstDones;

    cmp_minmax_seq #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .max_val  (max_val),
        .min_val  (min_val),
        .max_idx  (max_idx),
        .min_idx  (min_idx)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Runs one burst of n samples from sampleMem; optional in_valid gaps and a start poke mid-burst.
    task automatic applyStimulus(input int n, input bit gaps, input bit pokeStart);
        int   idx;
        int   lowLeft;
        logic rdy;
        logic vld;
        idx     = 0;
        lowLeft = 0;
        start   = 1'b1;
        len     = n[CNT_W-1:0];
        @(posedge clk); #1;
        start        = 1'b0;
        burstCycles  = 0;
        burstDones   = 0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                burstDones++;
                break;
            end
            vld      = (idx < n) && !(gaps && (c % 4 == 2));
            in_valid = vld;
            in_data  = (idx < n) ? sampleMem[idx] : 16'h0;
            start    = pokeStart && (c == 4);
            if (pokeStart && c == 4) len = '0;
            rdy = in_ready;
            if (lowLeft > 0) begin
                checkOutput("ready_low_in_cmp", {31'b0, rdy}, 32'd0);
                lowLeft--;
            end
            @(posedge clk);
            burstCycles++;
            if (rdy && vld) begin
                idx++;
                if (idx >= 2) lowLeft = CYC_PER - 1;
            end
            #1;
        end
        in_valid     = 1'b0;
        start        = 1'b0;
        burstAccepts = idx;
    endtask

    initial begin
        int idx;
        logic rdy;

        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rst_busy", {31'b0, busy}, 0);
        checkOutput("rst_done", {31'b0, done}, 0);
        checkOutput("rst_ready", {31'b0, in_ready}, 0);
        checkOutput("rst_max_val", {16'b0, max_val}, 0);
        checkOutput("rst_min_val", {16'b0, min_val}, 0);
        checkOutput("rst_max_idx", {27'b0, max_idx}, 0);
        checkOutput("rst_min_idx", {27'b0, min_idx}, 0);

        // len=5 {30,1,31,0,29}
        sampleMem[0] = 16'd30; sampleMem[1] = 16'd1; sampleMem[2] = 16'd31;
        sampleMem[3] = 16'd0;  sampleMem[4] = 16'd29;
        applyStimulus(5, 1'b0, 1'b0);
        checkOutput("b5_done_seen", burstDones, 1);
        checkOutput("b5_busy_at_done", {31'b0, busy}, 1);
        checkOutput("b5_accepts", burstAccepts, 5);
        checkOutput("b5_cycles", burstCycles, 1 + 4 * CYC_PER);
        checkOutput("b5_max_val", {16'b0, max_val}, 31);
        checkOutput("b5_max_idx", {27'b0, max_idx}, 2);
        checkOutput("b5_min_val", {16'b0, min_val}, 0);
        checkOutput("b5_min_idx", {27'b0, min_idx}, 3);
        @(posedge clk); #1;
        checkOutput("b5_done_pulse", {31'b0, done}, 0);
        checkOutput("b5_busy_after", {31'b0, busy}, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("b5_hold_max", {16'b0, max_val}, 31);
        checkOutput("b5_hold_min_idx", {27'b0, min_idx}, 3);

        // Reset mid-burst after two accepted samples
        start = 1'b1; len = 5'd4;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx == 2) break;
            in_data = (idx == 0) ? 16'd500 : 16'd600;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) idx++;
            #1;
        end
        checkOutput("mid_accepts", idx, 2);
        checkOutput("mid_busy", {31'b0, busy}, 1);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("mid_rst_busy", {31'b0, busy}, 0);
        checkOutput("mid_rst_done", {31'b0, done}, 0);
        checkOutput("mid_rst_ready", {31'b0, in_ready}, 0);
        checkOutput("mid_rst_max_val", {16'b0, max_val}, 0);
        checkOutput("mid_rst_min_val", {16'b0, min_val}, 0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_ready_low", {31'b0, in_ready}, 0);
        in_valid = 1'b0;

        // Ties: {7,7,3,3}
        sampleMem[0] = 16'd7; sampleMem[1] = 16'd7; sampleMem[2] = 16'd3; sampleMem[3] = 16'd3;
        applyStimulus(4, 1'b0, 1'b0);
        checkOutput("tie_done_seen", burstDones, 1);
        checkOutput("tie_max_val", {16'b0, max_val}, 7);
        checkOutput("tie_max_idx", {27'b0, max_idx}, 0);
        checkOutput("tie_min_val", {16'b0, min_val}, 3);
        checkOutput("tie_min_idx", {27'b0, min_idx}, 2);
        @(posedge clk); #1;

        // len=0: done one cycle after start, results cleared
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("len0_done_seen", burstDones, 1);
        checkOutput("len0_cycles", burstCycles, 0);
        checkOutput("len0_max_val", {16'b0, max_val}, 0);
        checkOutput("len0_min_val", {16'b0, min_val}, 0);
        @(posedge clk); #1;
        checkOutput("len0_done_pulse", {31'b0, done}, 0);

        // len=1 {65535}
        sampleMem[0] = 16'hFFFF;
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("len1_done_seen", burstDones, 1);
        checkOutput("len1_cycles", burstCycles, 1);
        checkOutput("len1_max_val", {16'b0, max_val}, 65535);
        checkOutput("len1_min_val", {16'b0, min_val}, 65535);
        checkOutput("len1_max_idx", {27'b0, max_idx}, 0);
        checkOutput("len1_min_idx", {27'b0, min_idx}, 0);
        @(posedge clk); #1;

        // Gaps in in_valid plus a start/len change while busy
        sampleMem[0] = 16'd100; sampleMem[1] = 16'd200; sampleMem[2] = 16'd50;
        sampleMem[3] = 16'd200; sampleMem[4] = 16'd50;  sampleMem[5] = 16'd150;
        applyStimulus(6, 1'b1, 1'b1);
        checkOutput("gap_done_seen", burstDones, 1);
        checkOutput("gap_accepts", burstAccepts, 6);
        checkOutput("gap_max_val", {16'b0, max_val}, 200);
        checkOutput("gap_max_idx", {27'b0, max_idx}, 1);
        checkOutput("gap_min_val", {16'b0, min_val}, 50);
        checkOutput("gap_min_idx", {27'b0, min_idx}, 2);
        @(posedge clk); #1;
        checkOutput("gap_done_pulse", {31'b0, done}, 0);
        checkOutput("gap_busy_after", {31'b0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
